dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single-port data memory between the host preload path, the LOAD data-fetch path and the STORE write-back path. It runs a round-robin arbitration with grant lock: the granted requester owns the port until it drops its request. The block muxes the owner's address, write-enable and data onto the memory, and steers read-valid back to the requester that issued each read. It sits between the data-fetch/store units and the data memory, beside the Control_Unit.

Parameters:
NREQ, 3, number of requesters (0 = host preload, 1 = load fetch, 2 = store write-back)
ADDR_W, 17, memory address width (matches instruction address field)
DATA_W, 8, memory data width

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
REQ  in  NREQ  per-requester port request, held high for the whole burst
VLD  in  NREQ  per-requester access strobe for this cycle
WE  in  NREQ  per-requester write enable (qualifies VLD)
ADDR  in  NREQ*ADDR_W  packed per-requester addresses, requester i at [i*ADDR_W +: ADDR_W]
WDATA  in  NREQ*DATA_W  packed per-requester write data
GNT  out  NREQ  registered one-hot grant
RVALID  out  NREQ  one-hot read-data-valid, one cycle after the read was issued
RDATA  out  DATA_W  read data broadcast to all requesters (= MEM_RDATA)
MEM_EN  out  1  memory access enable
MEM_WE  out  1  memory write enable
MEM_ADDR  out  ADDR_W  memory address
MEM_WDATA  out  DATA_W  memory write data
MEM_RDATA  in  DATA_W  memory read data, 1-cycle synchronous latency
BUSY  out  1  high while any grant is held

Behaviour:
- Reset (RSTN low, async): state ARB; GNT=0, RVALID=0, BUSY=0; round-robin pointer=0; owner index=0. MEM_* outputs are 0 because no grant is held. Reset mid-burst aborts the burst with no further memory access.
- FSM ARB: if any REQ bit is high, choose the first set bit scanning from the pointer upward (modulo NREQ). Register GNT=onehot(winner), owner=winner, go to OWN. GNT rises 1 cycle after REQ is first sampled. If no REQ bit is high, stay in ARB.
- FSM OWN: hold GNT. When REQ[owner]=0 is sampled, clear GNT, set pointer=(owner+1) mod NREQ and return to ARB. Next grant is earliest one cycle later, so there is exactly one dead cycle between owners. This also applies when the same requester re-requests immediately.
- Grant lock: other requesters cannot preempt the owner, regardless of their REQ.
- Memory mux (combinational from registered owner/GNT):
  - MEM_EN = GNT[owner] & VLD[owner]
  - MEM_WE = MEM_EN & WE[owner]
  - MEM_ADDR = ADDR[owner]
  - MEM_WDATA = WDATA[owner]
  - When MEM_EN=0, MEM_WE=0 and addr/wdata are don't-care. They are driven from the owner slice; no X is allowed.
- VLD from a non-granted requester is ignored: no memory access and no RVALID.
- Read return: a read issued in cycle t (MEM_EN & ~MEM_WE) gives RVALID[owner_at_t]=1 in cycle t+1, with RDATA=MEM_RDATA. The read tag is registered, so RVALID still reaches the issuer if the grant drops in cycle t+1.
- Same-cycle REQ drop with VLD: if the owner drops REQ while VLD is high in the same cycle, that access is still performed. The grant releases at the same clock edge.
- BUSY = |GNT.
- Widths: pointer and owner are $clog2(NREQ) bits; the pointer wraps NREQ-1 -> 0.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - requester index constants (REQ_HOST=0, REQ_LOAD=1, REQ_STORE=2)
  - the arbiter state enum {ARB, OWN}
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the req vector and pointer; outputs are the one-hot winner and its index.

Test Plan:
- Reset then idle: RSTN low mid-burst while GNT=010 -> GNT, RVALID and MEM_EN go to 0 immediately; after release the first REQ=001 gives GNT=001 one cycle later.
- Single burst: REQ[1] high 4 cycles, VLD reads at addresses 0x00010..0x00013 -> MEM_ADDR follows them, RVALID[1] pulses 4 times each 1 cycle later, RDATA equals the memory contents.
- Contention: REQ=111 from reset -> grant order 0, 1, 2, 0, each separated by one dead cycle after the owner drops REQ.
- Grant lock: owner 2 writing 0xA5 to 0x1FFFF while REQ[0] rises -> GNT stays 100 and memory receives the write; GNT=001 comes only after REQ[2] falls.
- Non-owner VLD: GNT=001 and VLD=010 with WE=010 -> MEM_WE=0 and no memory write occurs.
- Drop on last read: owner 1 issues a read while dropping REQ -> GNT clears next cycle and RVALID[1]=1 in that same cycle with the correct data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: requester indices and arbiter state type shared by the data-memory port arbiter
package dmem_arb_pkg;
  localparam int REQ_HOST  = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_STORE = 2;
  typedef enum logic {ARB, OWN} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request scanning upward from ptr
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    // scan from the far end so the request nearest the pointer is written last and wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        win_oh = '0;
        win_oh[(int'(ptr) + k) % NREQ] = 1'b1;
        win_idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin, grant-locked sharing of the single-port data memory
module dmem_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        VLD,
  input  logic [NREQ-1:0]        WE,
  input  logic [NREQ*ADDR_W-1:0] ADDR,
  input  logic [NREQ*DATA_W-1:0] WDATA,
  output logic [NREQ-1:0]        GNT,
  output logic [NREQ-1:0]        RVALID,
  output logic [DATA_W-1:0]      RDATA,
  output logic                   MEM_EN,
  output logic                   MEM_WE,
  output logic [ADDR_W-1:0]      MEM_ADDR,
  output logic [DATA_W-1:0]      MEM_WDATA,
  input  logic [DATA_W-1:0]      MEM_RDATA,
  output logic                   BUSY
);
  import dmem_arb_pkg::*;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, pick_oh;
  logic [IW-1:0]   owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(REQ), .ptr(ptr_q), .win_oh(pick_oh), .win_idx(pick_idx)
  );
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q == ARB && |REQ) begin
      state_d = OWN;
      gnt_d   = pick_oh;
      owner_d = pick_idx;
    end else if (state_q == OWN && !REQ[owner_q]) begin
      state_d = ARB;
      gnt_d   = '0;
      ptr_d   = owner_q == IW'(NREQ - 1) ? '0 : owner_q + IW'(1);
    end
  end
  always_comb begin
    MEM_EN    = gnt_q[owner_q] & VLD[owner_q];
    MEM_WE    = MEM_EN & WE[owner_q];
    MEM_ADDR  = ADDR[int'(owner_q)*ADDR_W +: ADDR_W];
    MEM_WDATA = WDATA[int'(owner_q)*DATA_W +: DATA_W];
    // gnt_q is one-hot on the owner, so it doubles as the read tag
    rvalid_d  = (MEM_EN & ~MEM_WE) ? gnt_q : '0;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ARB;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end
  assign GNT    = gnt_q;
  assign RVALID = rvalid_q;
  assign RDATA  = MEM_RDATA;
  assign BUSY   = |gnt_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a behavioural 1-cycle-latency memory behind the arbiter
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  req, vld, we, gnt, rvalid;
  logic [50:0] addr;
  logic [23:0] wdata;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [16:0] mem_addr;
  logic        mem_en, mem_we, busy;
  logic [7:0]  mem [0:131071];
  logic [10:0] exp_rd[$];
  logic [24:0] exp_wr[$];
  logic [2:0]  exp_gnt[$];
  logic [2:0]  prev_gnt = '0;
  int checks = 0, failures = 0;

  dmem_port_arbiter dut (
    .CLK(clk), .RSTN(rstn), .REQ(req), .VLD(vld), .WE(we), .ADDR(addr), .WDATA(wdata),
    .GNT(gnt), .RVALID(rvalid), .RDATA(rdata), .MEM_EN(mem_en), .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int a = 0; a < 131072; a++) mem[a] = 8'(a) + 8'h40;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid != 3'b000) begin
      if (exp_rd.size() == 0) chk("rvalid_unexpected", {29'd0, rvalid}, 32'd0);
      else begin
        logic [10:0] e;
        e = exp_rd.pop_front();
        chk("rvalid_tag", {29'd0, rvalid}, {29'd0, e[10:8]});
        chk("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
      end
    end
    if (mem_we) begin
      if (exp_wr.size() == 0) chk("write_unexpected", {15'd0, mem_addr}, 32'h1_0000_0);
      else begin
        logic [24:0] w;
        w = exp_wr.pop_front();
        chk("wr_addr", {15'd0, mem_addr}, {15'd0, w[24:8]});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, w[7:0]});
      end
    end
    if (gnt != prev_gnt && gnt != 3'b000) begin
      chk("dead_cycle", {29'd0, prev_gnt}, 32'd0);
      if (exp_gnt.size() == 0) chk("gnt_unexpected", {29'd0, gnt}, 32'd0);
      else chk("gnt_order", {29'd0, gnt}, {29'd0, exp_gnt.pop_front()});
    end
    prev_gnt = gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; req = '0; vld = '0; we = '0; addr = '0; wdata = '0;
    step(); step();
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    rstn = 1'b1;
    step();
    // reset in the middle of a load burst
    req = 3'b010; exp_gnt.push_back(3'b010);
    step(); step();
    chk("pre_rst_gnt", {29'd0, gnt}, 32'h2);
    vld = 3'b010; addr[17 +: 17] = 17'h00010;
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_gnt", {29'd0, gnt}, 32'd0);
    chk("async_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("async_rst_rvalid", {29'd0, rvalid}, 32'd0);
    req = '0; vld = '0;
    step(); rstn = 1'b1; step();
    req = 3'b001; exp_gnt.push_back(3'b001);
    step();
    chk("post_rst_gnt", {29'd0, gnt}, 32'h1);
    req = '0; step(); step();
    // single load burst, pointer now 1
    req = 3'b010; exp_gnt.push_back(3'b010);
    step();
    for (int i = 0; i < 4; i++) begin
      vld = 3'b010; addr[17 +: 17] = 17'h00010 + 17'(i);
      exp_rd.push_back({3'b010, 8'h50 + 8'(i)});
      #1 chk("burst_mem_addr", {15'd0, mem_addr}, 32'h10 + i);
      step();
    end
    vld = '0; req = '0; step(); step();
    // full contention from reset
    rstn = 1'b0; step(); rstn = 1'b1; step();
    exp_gnt.push_back(3'b001); exp_gnt.push_back(3'b010);
    exp_gnt.push_back(3'b100); exp_gnt.push_back(3'b001);
    req = 3'b111; step(); step();
    req = 3'b110; step();
    chk("dead_busy0", {31'd0, busy}, 32'd0);
    req = 3'b111; step(); step();
    req = 3'b101; step();
    chk("dead_busy1", {31'd0, busy}, 32'd0);
    req = 3'b111; step(); step();
    req = 3'b011; step();
    req = 3'b111; step();
    chk("contention_wrap", {29'd0, gnt}, 32'h1);
    req = '0; step(); step();
    // grant lock: store owner writes the top address while host requests
    req = 3'b100; exp_gnt.push_back(3'b100);
    step();
    req = 3'b101; vld = 3'b100; we = 3'b100;
    addr[34 +: 17] = 17'h1FFFF; wdata[16 +: 8] = 8'hA5;
    exp_wr.push_back({17'h1FFFF, 8'hA5});
    step();
    chk("lock_gnt0", {29'd0, gnt}, 32'h4);
    vld = '0; we = '0; step();
    chk("lock_gnt1", {29'd0, gnt}, 32'h4);
    vld = 3'b100; exp_rd.push_back({3'b100, 8'hA5});
    step();
    vld = '0; req = 3'b001; exp_gnt.push_back(3'b001);
    step(); step();
    chk("lock_handover", {29'd0, gnt}, 32'h1);
    // non-owner strobe must not reach memory
    vld = 3'b010; we = 3'b010; addr[17 +: 17] = 17'h00020; wdata[8 +: 8] = 8'hEE;
    #1;
    chk("nonowner_mem_we", {31'd0, mem_we}, 32'd0);
    chk("nonowner_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    vld = '0; we = '0; step();
    chk("nonowner_no_write", {24'd0, mem[17'h00020]}, 32'h60);
    req = '0; step(); step();
    // owner drops request on its final read
    req = 3'b010; exp_gnt.push_back(3'b010);
    step();
    vld = 3'b010; addr[17 +: 17] = 17'h00011; exp_rd.push_back({3'b010, 8'h51});
    step();
    req = '0; addr[17 +: 17] = 17'h00012; exp_rd.push_back({3'b010, 8'h52});
    step();
    vld = '0;
    chk("drop_gnt", {29'd0, gnt}, 32'd0);
    chk("drop_rvalid", {29'd0, rvalid}, 32'h2);
    chk("drop_rdata", {24'd0, rdata}, 32'h52);
    step(); step();
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("gnt_queue_empty", exp_gnt.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
